// File: rtl/enigma_if.sv
// Encoder bus: key/char/load inputs and cipher/status outputs.
// The master drives plaintext and controls; the slave returns ciphertext and status.
interface enigma_if;
  logic [7:0]  char_in;
  logic        key_press;
  logic        load;
  logic [4:0]  rotor_init;
  logic [7:0]  letter_out;
  logic        out_valid;
  logic        busy;
  logic        bad_char;
  logic [4:0]  rotor_pos;
  logic        wrap;
  logic [23:0] char_reg;

  modport master (
    output char_in, key_press, load, rotor_init,
    input  letter_out, out_valid, busy, bad_char, rotor_pos, wrap, char_reg
  );

  modport slave (
    input  char_in, key_press, load, rotor_init,
    output letter_out, out_valid, busy, bad_char, rotor_pos, wrap, char_reg
  );
endinterface

// File: rtl/enigma_encoder.sv
// Single-rotor Enigma (rotor I, reflector B) encrypting one letter per key press.
// A shared work register carries p -> x -> y -> z through the pipeline states.
module enigma_encoder (
  input  logic     clk,
  input  logic     resetn,
  enigma_if.slave  bus
);

  localparam logic [207:0] RotorWiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] RotorInv    = "UWYGADFPVZBECKMTHXSLRINQOJ";
  localparam logic [207:0] ReflWiring  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [2:0] {StIdle, StStep, StFwd, StRefl, StBack, StDone} state_e;

  function automatic logic [4:0] rom_lookup(input logic [207:0] tbl, input logic [4:0] idx);
    logic [7:0] c;
    c = 8'h41;
    for (int i = 0; i < 26; i++) begin
      if (idx == 5'(i)) c = tbl[8*(25-i) +: 8];
    end
    return 5'(c - 8'h41);
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // Borrow case adds 26 in 6 bits so the result never aliases through 32.
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + 6'd26 - {1'b0, b};
    return d[4:0];
  endfunction

  state_e      state_q, state_d;
  logic        key_q;
  logic [4:0]  pos_q, pos_d;
  logic [4:0]  w_q, w_d;
  logic [7:0]  letter_q, letter_d;
  logic [23:0] creg_q, creg_d;
  logic        ov_q, ov_d;
  logic        bad_q, bad_d;
  logic        wrap_q, wrap_d;

  logic        press;
  logic        is_letter;
  logic [4:0]  letter_idx;
  logic [7:0]  letter_new;

  assign press      = bus.key_press & ~key_q;
  assign letter_new = 8'h41 + {3'b000, w_q};

  always_comb begin
    is_letter  = 1'b0;
    letter_idx = '0;
    if (bus.char_in >= 8'h41 && bus.char_in <= 8'h5A) begin
      is_letter  = 1'b1;
      letter_idx = 5'(bus.char_in - 8'h41);
    end else if (bus.char_in >= 8'h61 && bus.char_in <= 8'h7A) begin
      is_letter  = 1'b1;
      letter_idx = 5'(bus.char_in - 8'h61);
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    w_d      = w_q;
    letter_d = letter_q;
    creg_d   = creg_q;
    ov_d     = 1'b0;
    bad_d    = 1'b0;
    wrap_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Load takes priority and swallows a coincident press.
        if (bus.load) begin
          pos_d = (bus.rotor_init <= 5'd25) ? bus.rotor_init : 5'd0;
        end else if (press) begin
          if (is_letter) begin
            w_d     = letter_idx;
            state_d = StStep;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      StStep: begin
        pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
        wrap_d  = (pos_q == 5'd25);
        state_d = StFwd;
      end
      StFwd: begin
        w_d     = sub26(rom_lookup(RotorWiring, add26(w_q, pos_q)), pos_q);
        state_d = StRefl;
      end
      StRefl: begin
        w_d     = rom_lookup(ReflWiring, w_q);
        state_d = StBack;
      end
      StBack: begin
        w_d     = sub26(rom_lookup(RotorInv, add26(w_q, pos_q)), pos_q);
        state_d = StDone;
      end
      StDone: begin
        letter_d = letter_new;
        creg_d   = {creg_q[15:0], letter_new};
        ov_d     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      key_q    <= 1'b0;
      pos_q    <= '0;
      w_q      <= '0;
      letter_q <= '0;
      creg_q   <= '0;
      ov_q     <= 1'b0;
      bad_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= bus.key_press;
      pos_q    <= pos_d;
      w_q      <= w_d;
      letter_q <= letter_d;
      creg_q   <= creg_d;
      ov_q     <= ov_d;
      bad_q    <= bad_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.letter_out = letter_q;
  assign bus.out_valid  = ov_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.bad_char   = bad_q;
  assign bus.rotor_pos  = pos_q;
  assign bus.wrap       = wrap_q;
  assign bus.char_reg   = creg_q;

endmodule

// File: tb/tb_enigma_encoder.sv
// Bench for enigma_encoder: vector table plus hand sequences, checked through
// a scoreboard of expected ciphertext popped whenever out_valid is seen.
module tb_enigma_encoder;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  enigma_if bus();

  enigma_encoder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  letter;
    logic [23:0] creg;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [4:0] init;
    logic [7:0] ch;
    logic       bad;
    logic [7:0] exp_letter;
    int         exp_pos;
    logic       exp_wrap;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          ov_count = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [23:0] m_creg;
  int          m_pos;
  vec_t        vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: forward via string, inverse by linear search.
  function automatic logic [7:0] model_enc(input logic [7:0] ch, input int pos);
    string rot;
    string refl;
    int p, x, y, t, z;
    rot  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    refl = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    p = (ch >= 8'h61) ? int'(ch) - 97 : int'(ch) - 65;
    x = ((int'(rot[(p + pos) % 26]) - 65) - pos + 26) % 26;
    y = int'(refl[x]) - 65;
    t = (y + pos) % 26;
    z = 0;
    for (int i = 0; i < 26; i++) begin
      if (int'(rot[i]) - 65 == t) z = (i - pos + 26) % 26;
    end
    return 8'(z + 65);
  endfunction

  task automatic expect_letter(input logic [7:0] l);
    exp_t e;
    m_creg   = {m_creg[15:0], l};
    e.letter = l;
    e.creg   = m_creg;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn && bus.out_valid === 1'b1) begin
      ov_count++;
      if (sb_q.size() == 0) begin
        check("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("letter_out", {24'd0, bus.letter_out}, {24'd0, mon_e.letter});
        check("char_reg", {8'd0, bus.char_reg}, {8'd0, mon_e.creg});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " letter_out"}, {24'd0, bus.letter_out}, 32'd0);
    check({tag, " char_reg"}, {8'd0, bus.char_reg}, 32'd0);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " bad_char"}, {31'd0, bus.bad_char}, 32'd0);
    check({tag, " wrap"}, {31'd0, bus.wrap}, 32'd0);
    check({tag, " rotor_pos"}, {27'd0, bus.rotor_pos}, 32'd0);
  endtask

  task automatic do_load(input logic [4:0] init);
    bus.load       = 1'b1;
    bus.rotor_init = init;
    tick();
    bus.load = 1'b0;
    m_pos = (init <= 5'd25) ? int'(init) : 0;
    check("rotor_pos after load", {27'd0, bus.rotor_pos}, m_pos);
    check("no wrap on load", {31'd0, bus.wrap}, 32'd0);
  endtask

  task automatic press_letter(input logic [7:0] ch, input logic [7:0] exp_letter,
                              input int exp_pos, input logic exp_wrap);
    int   k;
    logic seen;
    expect_letter(exp_letter);
    bus.char_in   = ch;
    bus.key_press = 1'b1;
    tick();
    check("busy after press", {31'd0, bus.busy}, 32'd1);
    k    = 0;
    seen = 1'b0;
    while (k < 10 && !seen) begin
      tick();
      k++;
      if (k == 1) check("wrap after step", {31'd0, bus.wrap}, {31'd0, exp_wrap});
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("out_valid latency", k, 32'd5);
    check("rotor_pos after encrypt", {27'd0, bus.rotor_pos}, exp_pos);
    check("busy after done", {31'd0, bus.busy}, 32'd0);
    // Key still held: must not retrigger.
    repeat (3) tick();
    check("held key no retrigger", {31'd0, bus.busy}, 32'd0);
    bus.key_press = 1'b0;
    tick();
    m_pos = exp_pos;
  endtask

  task automatic press_bad(input logic [7:0] ch);
    logic [4:0] pos0;
    pos0          = bus.rotor_pos;
    bus.char_in   = ch;
    bus.key_press = 1'b1;
    tick();
    check("bad_char pulse", {31'd0, bus.bad_char}, 32'd1);
    check("busy on bad char", {31'd0, bus.busy}, 32'd0);
    tick();
    check("bad_char one cycle", {31'd0, bus.bad_char}, 32'd0);
    check("busy stays low", {31'd0, bus.busy}, 32'd0);
    check("rotor_pos unchanged", {27'd0, bus.rotor_pos}, {27'd0, pos0});
    check("letter_out unchanged", {24'd0, bus.letter_out}, {24'd0, m_creg[7:0]});
    bus.key_press = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int         ov0;
    int         ep;
    logic [7:0] ch;
    bus.char_in    = 8'h00;
    bus.key_press  = 1'b0;
    bus.load       = 1'b0;
    bus.rotor_init = 5'd0;
    m_pos  = 0;
    m_creg = '0;
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    vt[0]  = '{1'b0, 5'd0,  8'h41, 1'b0, 8'h4E, 1, 1'b0};
    vt[1]  = '{1'b0, 5'd0,  8'h61, 1'b0, 8'h52, 2, 1'b0};
    vt[2]  = '{1'b1, 5'd0,  8'h4E, 1'b0, 8'h41, 1, 1'b0};
    vt[3]  = '{1'b1, 5'd25, 8'h41, 1'b0, 8'h48, 0, 1'b1};
    vt[4]  = '{1'b0, 5'd0,  8'h31, 1'b1, 8'h00, 0, 1'b0};
    vt[5]  = '{1'b1, 5'd25, 8'h48, 1'b0, 8'h41, 0, 1'b1};
    vt[6]  = '{1'b0, 5'd0,  8'h40, 1'b1, 8'h00, 0, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  8'h5B, 1'b1, 8'h00, 0, 1'b0};
    vt[8]  = '{1'b0, 5'd0,  8'h60, 1'b1, 8'h00, 0, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  8'h7B, 1'b1, 8'h00, 0, 1'b0};
    vt[10] = '{1'b0, 5'd0,  8'h7A, 1'b0, 8'h55, 1, 1'b0};
    vt[11] = '{1'b0, 5'd0,  8'h5A, 1'b0, 8'h56, 2, 1'b0};

    for (int i = 0; i < 12; i++) begin
      if (vt[i].ld) do_load(vt[i].init);
      if (vt[i].bad) press_bad(vt[i].ch);
      else press_letter(vt[i].ch, vt[i].exp_letter, vt[i].exp_pos, vt[i].exp_wrap);
    end

    // Out-of-range load clamps to zero.
    do_load(5'd7);
    do_load(5'd30);

    // Random letters across a wrap, checked against the reference model.
    do_load(5'd23);
    for (int i = 0; i < 5; i++) begin
      ch = 8'($urandom_range(0, 25)) + (($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41);
      ep = (m_pos + 1) % 26;
      press_letter(ch, model_enc(ch, ep), ep, m_pos == 25);
    end

    // Key toggled while busy: exactly one encryption.
    ov0 = ov_count;
    ep  = (m_pos + 1) % 26;
    expect_letter(model_enc(8'h42, ep));
    bus.char_in   = 8'h42;
    bus.key_press = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.key_press = ~bus.key_press;
      tick();
    end
    bus.key_press = 1'b0;
    repeat (10) tick();
    check("one out_valid for toggled key", ov_count - ov0, 32'd1);
    check("rotor_pos after toggled key", {27'd0, bus.rotor_pos}, ep);
    m_pos = ep;

    // Load and press in the same cycle: load wins.
    ov0            = ov_count;
    bus.load       = 1'b1;
    bus.rotor_init = 5'd9;
    bus.char_in    = 8'h43;
    bus.key_press  = 1'b1;
    tick();
    bus.load = 1'b0;
    check("load beats press pos", {27'd0, bus.rotor_pos}, 32'd9);
    check("load beats press busy", {31'd0, bus.busy}, 32'd0);
    repeat (8) tick();
    check("load beats press no out_valid", ov_count - ov0, 32'd0);
    bus.key_press = 1'b0;
    tick();
    m_pos = 9;

    // Reset asserted during REFL aborts the encryption.
    ov0           = ov_count;
    bus.char_in   = 8'h44;
    bus.key_press = 1'b1;
    repeat (3) tick();
    check("busy in refl", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    #1 check_reset_outputs("mid reset");
    m_pos  = 0;
    m_creg = '0;
    bus.key_press = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (8) tick();
    check("aborted no out_valid", ov_count - ov0, 32'd0);
    check("pos after abort", {27'd0, bus.rotor_pos}, 32'd0);

    press_letter(8'h41, 8'h4E, 1, 1'b0);

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/enigma_encoder.md
ENIGMA_ENCODER -- requirements
Module: enigma_encoder

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 resetn  in  1  reset, asynchronous and active-low.
REQ-003 char_in  in  8  plaintext character, ASCII; sampled on the press-detect cycle.
REQ-004 key_press  in  1  active-high level from debounced key; a rising edge requests one encryption.
REQ-005 load  in  1  active-high; loads rotor position from rotor_init.
REQ-006 rotor_init  in  5  initial rotor position, 0-25.
REQ-007 letter_out  out  8  ciphertext, uppercase ASCII 0x41-0x5A.
REQ-008 out_valid  out  1  one-cycle pulse; letter_out is new.
REQ-009 busy  out  1  high while not in IDLE.
REQ-010 bad_char  out  1  one-cycle pulse; rejected input.
REQ-011 rotor_pos  out  5  current rotor position, 0-25.
REQ-012 wrap  out  1  one-cycle pulse when rotor steps 25 -> 0.
REQ-013 char_reg  out  24  last three ciphertext chars; [7:0] newest, [23:16] oldest.

Function
REQ-014 Rotor wiring fixed to Enigma I rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ"; reflector fixed to B "YRUHQSLDPXNGOKMIEBFZCWVJAT"; both are constant ROM in the block.
REQ-015 Letter index p = char_in-0x41 for 0x41-0x5A, char_in-0x61 for 0x61-0x7A; all other codes are non-letters.
REQ-016 Press detect: key_q registers key_press each cycle; press = key_press & ~key_q, evaluated only in IDLE.
REQ-017 FSM states IDLE, STEP, FWD, REFL, BACK, DONE; IDLE->STEP on press with a letter; STEP->FWD->REFL->BACK->DONE unconditionally; DONE->IDLE.
REQ-018 Press cycle in IDLE latches p; STEP sets pos = (pos==25) ? 0 : pos+1 and pulses wrap on 25->0.
REQ-019 FWD: x = ROTOR[(p+pos) mod 26] - pos, mod 26.
REQ-020 REFL: y = REFL[x].
REQ-021 BACK: z = ROTOR_INV[(y+pos) mod 26] - pos, mod 26; all modular arithmetic on 5-bit values with explicit +26 correction, no wrap through 32.
REQ-022 DONE: letter_out = z+0x41, out_valid high exactly one cycle, char_reg shifts left by 8 with new letter in [7:0].
REQ-023 Latency: out_valid asserts on the 5th rising edge after the edge at which the press was detected.
REQ-024 Presses while busy are ignored and not queued; a level held high across DONE does not retrigger.
REQ-025 Non-letter press in IDLE: bad_char pulses next cycle, FSM stays IDLE, no rotor step, letter_out and char_reg unchanged.
REQ-026 load in IDLE: pos = rotor_init if <=25, else 0; no wrap pulse; load while busy ignored.
REQ-027 load and press in the same IDLE cycle: load wins, press discarded, no encryption.
REQ-028 Encryption is self-reciprocal: same start position plus ciphertext input reproduces plaintext.

Reset
REQ-029 resetn low: state IDLE, pos 0, key_q 0, letter_out 0x00, char_reg 0, out_valid/busy/bad_char/wrap 0, immediately and asynchronously.
REQ-030 Reset mid-encryption aborts it: no out_valid, pos returns to 0.

Verification
REQ-031 Reset, press 'A' (0x41) -> out_valid 5 edges later, letter_out 0x4E 'N', rotor_pos 1.
REQ-032 Second press 'a' (0x61) -> letter_out 0x52 'R', char_reg 0x004E52.
REQ-033 load rotor_init=0, press 'N' -> letter_out 'A' (reciprocity).
REQ-034 load rotor_init=25, press 'A' -> wrap pulses in STEP, rotor_pos 0; load rotor_init=30 -> rotor_pos 0.
REQ-035 Press '1' (0x31) -> bad_char one cycle, busy never high, rotor_pos unchanged; key_press toggled during busy -> exactly one out_valid.
REQ-036 resetn low during REFL -> no out_valid, all outputs at reset values; load+press same cycle -> pos loaded, no out_valid.
